// File: rtl/imm_gen_pkg.sv
// Shared constants for the RV64I immediate generator: opcodes, format codes, default width.
package imm_gen_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;
    localparam int unsigned OPC_W        = 7;
    localparam int unsigned FMT_W        = 3;

    localparam logic [OPC_W-1:0] OP_LOAD     = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [OPC_W-1:0] OP_IMM      = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_IMM_32   = 7'b0011011;
    localparam logic [OPC_W-1:0] OP_JALR     = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [OPC_W-1:0] OP_STORE    = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH   = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LUI      = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC    = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL      = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_OP       = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_OP_32    = 7'b0111011;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

endpackage

// File: rtl/imm_gen_decode.sv
// Combinational decode of an instruction word into format, sign-extended immediate and illegal flag.
module imm_gen_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] immediate,
    output fmt_e            format,
    output logic            illegal
);

    logic [OPC_W-1:0] opcode;
    logic [11:0]      raw_i;
    logic [11:0]      raw_s;
    logic [12:0]      raw_b;
    logic [31:0]      raw_u;
    logic [20:0]      raw_j;

    assign opcode = instr[6:0];
    assign raw_i  = instr[31:20];
    assign raw_s  = {instr[31:25], instr[11:7]};
    assign raw_b  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign raw_u  = {instr[31:12], 12'b0};
    assign raw_j  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Format classification; anything outside the supported opcode set is illegal
    always_comb begin
        format  = FMT_NONE;
        illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OP_LOAD, OP_MISC_MEM, OP_IMM, OP_IMM_32, OP_JALR, OP_SYSTEM: format = FMT_I;
                OP_STORE:          format = FMT_S;
                OP_BRANCH:         format = FMT_B;
                OP_LUI, OP_AUIPC:  format = FMT_U;
                OP_JAL:            format = FMT_J;
                OP_OP, OP_OP_32:   format = FMT_NONE;
                default:           illegal = 1'b1;
            endcase
        end
    end

    // Signed casts sign-extend every raw field from instr[31]
    always_comb begin
        immediate = '0;
        case (format)
            FMT_I:   immediate = XLEN'($signed(raw_i));
            FMT_S:   immediate = XLEN'($signed(raw_s));
            FMT_B:   immediate = XLEN'($signed(raw_b));
            FMT_U:   immediate = XLEN'($signed(raw_u));
            FMT_J:   immediate = XLEN'($signed(raw_j));
            default: immediate = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen.sv
// Registered immediate generator: one-cycle decode latency with stall hold and valid-qualified update.
module imm_gen
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Valid,
    input  logic             i_Stall,
    input  logic [31:0]      i_Instr,
    output logic             o_Valid,
    output logic [XLEN-1:0]  o_Immediate,
    output logic [FMT_W-1:0] o_Format,
    output logic             o_Illegal
);

    logic [XLEN-1:0] dec_immediate;
    fmt_e            dec_format;
    logic            dec_illegal;

    imm_gen_decode #(.XLEN(XLEN)) u_decode (
        .instr     (i_Instr),
        .immediate (dec_immediate),
        .format    (dec_format),
        .illegal   (dec_illegal)
    );

    // Stall freezes everything; otherwise payload only moves on a valid input
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Valid     <= 1'b0;
            o_Immediate <= '0;
            o_Format    <= FMT_W'(FMT_NONE);
            o_Illegal   <= 1'b0;
        end else if (!i_Stall) begin
            o_Valid <= i_Valid;
            if (i_Valid) begin
                o_Immediate <= dec_immediate;
                o_Format    <= FMT_W'(dec_format);
                o_Illegal   <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: directed vector table, stall/valid/reset sequences, random vs. reference model.
module tb_imm_gen;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        stall;
    logic [31:0] instr;

    logic        v64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
    logic        v32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;

    int checks = 0;
    int errors = 0;

    imm_gen #(.XLEN(64)) dut64 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(valid), .i_Stall(stall), .i_Instr(instr),
        .o_Valid(v64), .o_Immediate(imm64), .o_Format(fmt64), .o_Illegal(ill64)
    );

    imm_gen #(.XLEN(32)) dut32 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(valid), .i_Stall(stall), .i_Instr(instr),
        .o_Valid(v32), .o_Immediate(imm32), .o_Format(fmt32), .o_Illegal(ill32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: interpret the opcode table literally
    function automatic logic [2:0] ref_fmt(input logic [31:0] w);
        if (w[1:0] != 2'b11) return 3'd0;
        case (w[6:0])
            7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73: return 3'd1;
            7'h23: return 3'd2;
            7'h63: return 3'd3;
            7'h37, 7'h17: return 3'd4;
            7'h6F: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [31:0] w);
        if (w[1:0] != 2'b11) return 1'b1;
        case (w[6:0])
            7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic longint sx(input longint v, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (v >= half) ? v - 2 * half : v;
    endfunction

    // Immediate value as an integer built from weighted bit fields
    function automatic logic [63:0] ref_imm(input logic [31:0] w);
        longint u;
        longint b31;
        longint v;
        u   = longint'(w);
        b31 = (u >> 31) & 1;
        case (ref_fmt(w))
            3'd1: v = sx((u >> 20) & 4095, 12);
            3'd2: v = sx(((u >> 25) & 127) * 32 + ((u >> 7) & 31), 12);
            3'd3: v = sx(b31 * 4096 + ((u >> 7) & 1) * 2048 + ((u >> 25) & 63) * 32
                         + ((u >> 8) & 15) * 2, 13);
            3'd4: v = sx(((u >> 12) & 20'hFFFFF) * 4096, 32);
            3'd5: v = sx(b31 * 1048576 + ((u >> 12) & 255) * 4096 + ((u >> 20) & 1) * 2048
                         + ((u >> 21) & 1023) * 2, 21);
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(v64), 64'd0);
        chk({tag, "_imm"},   imm64,    64'd0);
        chk({tag, "_fmt"},   64'(fmt64), 64'd0);
        chk({tag, "_ill"},   64'(ill64), 64'd0);
        chk({tag, "_imm32"}, 64'(imm32), 64'd0);
    endtask

    vec_t vecs[$];
    logic [6:0] opcs[13];

    initial begin
        logic [63:0] hold_imm;
        logic        e_valid;
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        logic [31:0] w;

        vecs.push_back('{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0});
        vecs.push_back('{32'hFE113C23, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0});
        vecs.push_back('{32'h00000463, 64'h0000000000000008, 3'd3, 1'b0});
        vecs.push_back('{32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0});
        vecs.push_back('{32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 64'h0,                3'd0, 1'b1});
        vecs.push_back('{32'hABCDFFFF, 64'h0,                3'd0, 1'b1});
        vecs.push_back('{32'h002081B3, 64'h0,                3'd0, 1'b0});
        vecs.push_back('{32'h80000090, 64'h0,                3'd0, 1'b1});
        vecs.push_back('{32'h7FF00013, 64'h00000000000007FF, 3'd1, 1'b0});

        opcs = '{7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63,
                 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};

        rst_n = 1'b0;
        valid = 1'b1;
        stall = 1'b0;
        instr = 32'hFFF00093;
        #1;
        chk_zero("reset");
        step();
        chk_zero("reset_ignores_input");
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            valid = 1'b1;
            instr = vecs[i].instr;
            step();
            chk($sformatf("tbl%0d_valid", i), 64'(v64), 64'd1);
            chk($sformatf("tbl%0d_imm", i), imm64, vecs[i].imm);
            chk($sformatf("tbl%0d_fmt", i), 64'(fmt64), 64'(vecs[i].fmt));
            chk($sformatf("tbl%0d_ill", i), 64'(ill64), 64'(vecs[i].ill));
            chk($sformatf("tbl%0d_imm32", i), 64'(imm32), 64'(vecs[i].imm[31:0]));
        end

        // Narrow instance on lui
        valid = 1'b1;
        instr = 32'h800000B7;
        step();
        chk("xlen32_lui", 64'(imm32), 64'h80000000);
        chk("xlen32_fmt", 64'(fmt32), 64'd4);

        // Stall holds everything for three cycles
        instr = 32'hFFF00093;
        step();
        hold_imm = 64'hFFFFFFFFFFFFFFFF;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            valid = c[0];
            instr = 32'hFE113C23 + 32'(c);
            step();
            chk($sformatf("stall%0d_valid", c), 64'(v64), 64'd1);
            chk($sformatf("stall%0d_imm", c), imm64, hold_imm);
            chk($sformatf("stall%0d_fmt", c), 64'(fmt64), 64'd1);
            chk($sformatf("stall%0d_ill", c), 64'(ill64), 64'd0);
        end
        stall = 1'b0;
        valid = 1'b0;
        instr = 32'h800000B7;
        step();
        chk("novalid_valid", 64'(v64), 64'd0);
        chk("novalid_imm", imm64, hold_imm);
        chk("novalid_fmt", 64'(fmt64), 64'd1);

        // Reset mid-cycle clears at once
        valid = 1'b1;
        instr = 32'hFFDFF06F;
        step();
        chk("pre_rst_imm", imm64, 64'hFFFFFFFFFFFFFFFC);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;
        step();
        chk_zero("post_rst_idle");

        // Random traffic vs. reference model
        e_valid = 1'b0;
        e_imm   = '0;
        e_fmt   = 3'd0;
        e_ill   = 1'b0;
        for (int n = 0; n < 400; n++) begin
            w = $urandom;
            if ($urandom_range(0, 7) != 0)
                w = {w[31:7], opcs[$urandom_range(0, 12)]};
            instr = w;
            valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0);
            if (!stall) begin
                e_valid = valid;
                if (valid) begin
                    e_imm = ref_imm(w);
                    e_fmt = ref_fmt(w);
                    e_ill = ref_ill(w);
                end
            end
            step();
            chk($sformatf("rnd%0d_valid", n), 64'(v64), 64'(e_valid));
            chk($sformatf("rnd%0d_imm", n), imm64, e_imm);
            chk($sformatf("rnd%0d_fmt", n), 64'(fmt64), 64'(e_fmt));
            chk($sformatf("rnd%0d_ill", n), 64'(ill64), 64'(e_ill));
            chk($sformatf("rnd%0d_imm32", n), 64'(imm32), 64'(e_imm[31:0]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_gen.md
IMM_GEN -- requirements
Module: imm_gen

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning the output immediate width; legal values are 32 and 64.
REQ-002 SHALL have port i_Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_Rst_n, input, 1, the reset; asynchronous, active-low.
REQ-004 SHALL have port i_Valid, input, 1, meaning i_Instr holds a fetched instruction this cycle.
REQ-005 SHALL have port i_Stall, input, 1, meaning freeze all registered outputs this cycle.
REQ-006 SHALL have port i_Instr, input, 32, the raw RV64I instruction word.
REQ-007 SHALL have port o_Valid, output, 1, meaning o_Immediate, o_Format and o_Illegal hold a decoded result.
REQ-008 SHALL have port o_Immediate, output, XLEN, the sign-extended immediate.
REQ-009 SHALL have port o_Format, output, 3, the instruction format code: NONE=0, I=1, S=2, B=3, U=4, J=5.
REQ-010 SHALL have port o_Illegal, output, 1, meaning the opcode is not a supported RV64I opcode.

Function
REQ-011 SHALL decode the format from i_Instr[6:0]:
- I for 0000011, 0001111, 0010011, 0011011, 1100111, 1110011.
- S for 0100011; B for 1100011; U for 0110111 and 0010111; J for 1101111.
- NONE for 0110011 and 0111011.
REQ-012 SHALL form the I immediate as sext(instr[31:20]); shift opcodes get no special masking, because shamt is masked downstream.
REQ-013 SHALL form the S immediate as sext({instr[31:25], instr[11:7]}).
REQ-014 SHALL form the B immediate as sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
REQ-015 SHALL form the U immediate as sext({instr[31:12], 12 zero bits}).
REQ-016 SHALL form the J immediate as sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
REQ-017 SHALL sign-extend every immediate from instr[31] to XLEN bits.
REQ-018 SHALL output immediate 0 with format NONE for the NONE format, unknown opcodes, and words where instr[1:0] != 11.
REQ-019 SHALL set o_Illegal=1 for any opcode not listed in REQ-011, and for instr[1:0] != 11; o_Illegal SHALL be 0 otherwise.
REQ-020 SHALL register all outputs with 1-cycle latency: the result of an input sampled at edge N appears after edge N.
REQ-021 SHALL, when i_Stall=1, hold every output including o_Valid; i_Stall SHALL take priority over i_Valid.
REQ-022 SHALL, when i_Stall=0:
- load o_Valid from i_Valid;
- update o_Immediate, o_Format and o_Illegal only when i_Valid=1, holding them otherwise.
REQ-023 SHALL have no combinational path from any input to any output.

Reset
REQ-024 SHALL, while i_Rst_n=0 and independent of i_Clk, drive o_Valid=0, o_Immediate=0, o_Format=NONE and o_Illegal=0.
REQ-025 SHALL ignore inputs during reset; the first decode SHALL occur on the first rising edge after reset is released.
REQ-026 SHALL, when reset is asserted mid-stream, discard any in-flight result immediately.

Structure
REQ-027 SHALL place the opcode constants, the format codes (3-bit type) and the XLEN default in shared package imm_gen_pkg.
REQ-028 SHALL split decode into one combinational sub-module imm_gen_decode (instr -> immediate, format, illegal), with the registers in imm_gen.

Verification
REQ-029 SHALL cover: 0xFFF00093 (addi x1,x0,-1), i_Valid=1 -> next cycle o_Immediate=0xFFFFFFFFFFFFFFFF, o_Format=I, o_Illegal=0, o_Valid=1.
REQ-030 SHALL cover: 0xFE113C23 (sd x1,-8(x2)) -> 0xFFFFFFFFFFFFFFF8, S; then 0x00000463 (beq +8) -> 0x0000000000000008, B.
REQ-031 SHALL cover: 0x800000B7 (lui) -> 0xFFFFFFFF80000000, U; then 0xFFDFF06F (jal -4) -> 0xFFFFFFFFFFFFFFFC, J.
REQ-032 SHALL cover: 0xFFFFFFFF and 0xABCDFFFF (opcode 0x7F) -> o_Immediate=0, o_Format=NONE, o_Illegal=1; and 0x002081B3 (add) -> 0, NONE, o_Illegal=0.
REQ-033 SHALL cover: i_Stall=1 for 3 cycles with changing i_Instr -> outputs unchanged; and i_Valid=0 -> o_Valid=0 with the previous immediate held.
REQ-034 SHALL cover: i_Rst_n asserted between clock edges -> outputs zero immediately; XLEN=32 with 0x800000B7 -> 0x80000000.
